// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : per-channel PWM period / high-time capture, W1C status, level IRQ
// Revision    : 1.0
// ============================================================================
module pwm_capture #(
    parameter int CHANNEL = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    input  logic [CHANNEL-1:0] pwm_i,
    output logic               irq_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [7:0] ADDR_CTRL   = 8'h20;
    localparam logic [7:0] ADDR_STATUS = 8'h21;

    logic [7:0]                    addr_inner;
    logic                          ctrl_we;
    logic                          status_we;
    logic [CHANNEL-1:0]            s1, s2, s3;
    logic [CHANNEL-1:0]            rise, fall;
    logic [CHANNEL-1:0]            en, ie;
    logic [CHANNEL-1:0]            valid, ovf;
    logic [CHANNEL-1:0]            valid_set, ovf_set;
    logic [CHANNEL-1:0]            valid_clr, ovf_clr;
    logic [CHANNEL-1:0][31:0]      rd_ch;
    logic                          unused_bits;

    assign addr_inner  = addr_i[23:16];
    assign ctrl_we     = we_i && (addr_inner == ADDR_CTRL);
    assign status_we   = we_i && (addr_inner == ADDR_STATUS);
    assign valid_clr   = status_we ? data_i[CHANNEL-1:0]  : '0;
    assign ovf_clr     = status_we ? data_i[16 +: CHANNEL] : '0;
    assign unused_bits = ^{data_i, addr_i[31:24], addr_i[15:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pwm_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Hardware set is OR-ed in after the W1C mask so a coincident set survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en    <= '0;
            ie    <= '0;
            valid <= '0;
            ovf   <= '0;
            irq_o <= 1'b0;
        end else begin
            if (ctrl_we) begin
                en <= data_i[CHANNEL-1:0];
                ie <= data_i[16 +: CHANNEL];
            end
            valid <= (valid & ~valid_clr) | valid_set;
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
            irq_o <= |(valid & ie);
        end
    end

    for (genvar g = 0; g < CHANNEL; g++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hi_tmp;
        logic [CNT_W-1:0] prd;
        logic [CNT_W-1:0] hgh;
        logic             in_meas;

        assign in_meas      = en[g] && (state == ST_MEAS);
        assign valid_set[g] = in_meas && rise[g];
        assign ovf_set[g]   = in_meas && !rise[g] && (cnt == '1);

        // The FSM sees the pre-write en, so a capture coincident with a CTRL write still completes.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                hi_tmp <= '0;
                prd    <= '0;
                hgh    <= '0;
            end else if (!en[g]) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM: begin
                        if (rise[g]) begin
                            cnt   <= CNT_W'(1);
                            state <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (rise[g]) begin
                            prd <= cnt;
                            hgh <= hi_tmp;
                            cnt <= CNT_W'(1);
                        end else if (cnt == '1) begin
                            cnt   <= '0;
                            state <= ST_ARM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (fall[g]) begin
                                hi_tmp <= cnt;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign rd_ch[g] = (addr_inner == 8'(g))      ? 32'(prd) :
                          (addr_inner == 8'(16 + g)) ? 32'(hgh) : 32'd0;
    end

    always_comb begin
        data_o = '0;
        case (addr_inner)
            ADDR_CTRL: begin
                data_o[CHANNEL-1:0]  = en;
                data_o[16 +: CHANNEL] = ie;
            end
            ADDR_STATUS: begin
                data_o[CHANNEL-1:0]  = valid;
                data_o[16 +: CHANNEL] = ovf;
            end
            default: begin
                for (int n = 0; n < CHANNEL; n++) begin
                    data_o = data_o | rd_ch[n];
                end
            end
        endcase
    end

endmodule
`default_nettype wire
